// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared state encodings and access-size constants for the load/store unit
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LS_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LS_SIZE_HALF = 2'b01;
  localparam logic [1:0] LS_SIZE_WORD = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/store-lane replication and load lane extract with sign/zero extension
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      LS_SIZE_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      LS_SIZE_HALF: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Word accesses (and the undefined size 11) return the bus word untouched.
  always_comb begin
    ld_byte   = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      LS_SIZE_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
      LS_SIZE_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
      default:      ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store bus controller with timeout fault and write-back
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_WIDTH    = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    de_lsu_flag,
  input  logic                    de_alu_l_flag,
  input  logic                    de_alu_s_flag,
  input  logic [1:0]              de_alu_ls_size,
  input  logic                    de_lsu_unsigned,
  input  logic [4:0]              de_rd_addr,
  input  logic [DATA_WIDTH-1:0]   alu_lsu_addr,
  input  logic                    alu_int_l_misa,
  input  logic                    alu_int_s_misa,
  input  logic [DATA_WIDTH-1:0]   reg2_data,
  output logic                    lsu_bus_req,
  output logic                    lsu_bus_we,
  output logic [DATA_WIDTH-1:0]   lsu_bus_addr,
  output logic [DATA_WIDTH/8-1:0] lsu_bus_be,
  output logic [DATA_WIDTH-1:0]   lsu_bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_err,
  output logic                    lsu_stall,
  output logic                    lsu_wb_valid,
  output logic [4:0]              lsu_wb_rd,
  output logic [DATA_WIDTH-1:0]   lsu_wb_data,
  output logic                    lsu_int_fault,
  output logic                    lsu_int_is_store
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

  lsu_state_e state_q, state_d;
  logic [TO_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
  logic [1:0]              size_q;
  logic                    uns_q, we_q;
  logic [4:0]              rd_q;
  logic [DATA_WIDTH/8-1:0] be_q;

  logic                    accept, resp, timeout, in_req, wb_fire;
  logic [DATA_WIDTH/8-1:0] st_be;
  logic [DATA_WIDTH-1:0]   st_wdata, ld_data;

  // The ALU has already raised the misalignment exception, so such ops never reach the bus.
  assign accept = (state_q == LSU_IDLE) & de_lsu_flag & (de_alu_l_flag | de_alu_s_flag)
                & ~(alu_int_l_misa | alu_int_s_misa);

  lsu_align u_align (
    .st_off_i      (alu_lsu_addr[1:0]),
    .st_size_i     (de_alu_ls_size),
    .st_data_i     (reg2_data),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_off_i      (addr_q[1:0]),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (bus_rdata),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + TO_WIDTH'(1);
    resp    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = LSU_REQ;
      end
      LSU_REQ: begin
        if (bus_gnt && bus_rvalid) begin
          resp    = 1'b1;
          state_d = LSU_IDLE;
        end else if (bus_gnt) begin
          cnt_d   = '0;
          state_d = LSU_WAIT;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = LSU_IDLE;
        end
      end
      LSU_WAIT: begin
        if (bus_rvalid) begin
          resp    = 1'b1;
          state_d = LSU_IDLE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
    if (state_d == LSU_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      be_q    <= '0;
    end else if (accept) begin
      addr_q  <= alu_lsu_addr;
      wdata_q <= st_wdata;
      size_q  <= de_alu_ls_size;
      uns_q   <= de_lsu_unsigned;
      we_q    <= de_alu_s_flag;
      rd_q    <= de_rd_addr;
      be_q    <= st_be;
    end
  end

  assign in_req  = (state_q == LSU_REQ);
  assign wb_fire = resp & ~bus_err & ~we_q;

  assign lsu_bus_req      = in_req;
  assign lsu_bus_we       = in_req & we_q;
  assign lsu_bus_addr     = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign lsu_bus_be       = in_req ? be_q : '0;
  assign lsu_bus_wdata    = in_req ? wdata_q : '0;

  assign lsu_stall        = ((state_q != LSU_IDLE) & ~(resp | timeout)) | accept;
  assign lsu_wb_valid     = wb_fire;
  assign lsu_wb_rd        = wb_fire ? rd_q : '0;
  assign lsu_wb_data      = wb_fire ? ld_data : '0;
  assign lsu_int_fault    = (resp & bus_err) | timeout;
  assign lsu_int_is_store = ((resp & bus_err) | timeout) & we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and randomized self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_lsu_flag, de_alu_l_flag, de_alu_s_flag, de_lsu_unsigned;
  logic [1:0]  de_alu_ls_size;
  logic [4:0]  de_rd_addr;
  logic [31:0] alu_lsu_addr, reg2_data;
  logic        alu_int_l_misa, alu_int_s_misa;
  logic        lsu_bus_req, lsu_bus_we;
  logic [31:0] lsu_bus_addr, lsu_bus_wdata;
  logic [3:0]  lsu_bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
  logic        lsu_stall, lsu_wb_valid, lsu_int_fault, lsu_int_is_store;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .de_lsu_flag(de_lsu_flag), .de_alu_l_flag(de_alu_l_flag), .de_alu_s_flag(de_alu_s_flag),
    .de_alu_ls_size(de_alu_ls_size), .de_lsu_unsigned(de_lsu_unsigned), .de_rd_addr(de_rd_addr),
    .alu_lsu_addr(alu_lsu_addr), .alu_int_l_misa(alu_int_l_misa), .alu_int_s_misa(alu_int_s_misa),
    .reg2_data(reg2_data),
    .lsu_bus_req(lsu_bus_req), .lsu_bus_we(lsu_bus_we), .lsu_bus_addr(lsu_bus_addr),
    .lsu_bus_be(lsu_bus_be), .lsu_bus_wdata(lsu_bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .lsu_stall(lsu_stall), .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd),
    .lsu_wb_data(lsu_wb_data), .lsu_int_fault(lsu_int_fault), .lsu_int_is_store(lsu_int_is_store)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte lanes picked out arithmetically, sizes 11 and 10 both mean a 4-byte word.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input int off);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return 4'(((1 << n) - 1) << ((n == 4) ? 0 : off));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns, input int off,
                                         input logic [31:0] rd);
    longint v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (rd >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    de_lsu_flag = 0; de_alu_l_flag = 0; de_alu_s_flag = 0; de_lsu_unsigned = 0;
    de_alu_ls_size = 0; de_rd_addr = 0; alu_int_l_misa = 0; alu_int_s_misa = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
  endtask

  task automatic drive_op(input bit ld, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd);
    @(posedge clk); #1;
    de_lsu_flag = 1; de_alu_l_flag = ld; de_alu_s_flag = !ld; de_alu_ls_size = sz;
    de_lsu_unsigned = uns; de_rd_addr = rd; alu_lsu_addr = addr; reg2_data = sdata;
    #1;
    check("accept_stall", lsu_stall, 1);
    check("accept_req", lsu_bus_req, 0);
  endtask

  // One full transaction: gd REQ cycles without gnt, then rvd cycles until rvalid (0 = same cycle as gnt).
  task automatic do_op(input bit ld, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input int gd, input int rvd,
                       input logic [31:0] rdata, input bit err);
    int  off;
    bit  wbe;
    off = int'(addr[1:0]);
    drive_op(ld, sz, uns, addr, sdata, rd);
    for (int k = 0; k <= gd; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        idle_inputs();
        alu_lsu_addr = $urandom; reg2_data = $urandom;
      end
      bus_gnt = (k == gd); bus_rvalid = (k == gd) && (rvd == 0);
      bus_rdata = rdata; bus_err = err && bus_rvalid;
      #1;
      check("req", lsu_bus_req, 1);
      check("req_we", lsu_bus_we, !ld);
      check("req_addr", lsu_bus_addr, {addr[31:2], 2'b00});
      check("req_be", lsu_bus_be, m_be(sz, off));
      if (!ld) check("req_wdata", lsu_bus_wdata, m_wdata(sz, sdata));
      check("req_stall", lsu_stall, (k == gd && rvd == 0) ? 0 : 1);
    end
    for (int j = 1; j <= rvd; j++) begin
      @(posedge clk); #1;
      bus_gnt = 0; bus_rvalid = (j == rvd); bus_err = err && bus_rvalid;
      #1;
      check("wait_req", lsu_bus_req, 0);
      check("wait_stall", lsu_stall, (j == rvd) ? 0 : 1);
    end
    wbe = ld && !err;
    check("wb_valid", lsu_wb_valid, wbe);
    check("wb_rd", lsu_wb_rd, wbe ? rd : 5'd0);
    check("wb_data", lsu_wb_data, wbe ? m_load(sz, uns, off, rdata) : 32'd0);
    check("fault", lsu_int_fault, err);
    check("is_store", lsu_int_is_store, err && !ld);
    @(posedge clk); #1;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
    #1;
    check("post_stall", lsu_stall, 0);
    check("post_req", lsu_bus_req, 0);
    check("post_wb", lsu_wb_valid, 0);
  endtask

  initial begin
    idle_inputs();
    alu_lsu_addr = 0; reg2_data = 0; bus_rdata = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", lsu_bus_req, 0);
    check("rst_stall", lsu_stall, 0);
    check("rst_addr", lsu_bus_addr, 0);
    check("rst_wb", lsu_wb_valid, 0);
    check("rst_fault", lsu_int_fault, 0);
    rst_n = 1;

    // SB 0xDEADBEEF @0x1002 with one-cycle gnt delay: be 0100, lanes 0xEFEFEFEF, three stall cycles
    do_op(0, 2'd0, 0, 32'h1002, 32'hDEADBEEF, 5'd0, 1, 1, 32'h0, 0);
    check("sb_be_const", m_be(2'd0, 2), 4'b0100);
    do_op(1, 2'd0, 0, 32'h1003, 32'h0, 5'd7, 0, 1, 32'h80FF_0000, 0);
    do_op(1, 2'd0, 1, 32'h1003, 32'h0, 5'd8, 0, 1, 32'h80FF_0000, 0);
    do_op(1, 2'd1, 0, 32'h1002, 32'h0, 5'd9, 0, 2, 32'h8001_1234, 0);
    do_op(1, 2'd2, 0, 32'h1004, 32'h0, 5'd10, 0, 0, 32'hCAFE_F00D, 0);
    do_op(0, 2'd2, 0, 32'h2000, 32'h1234_5678, 5'd0, 0, 1, 32'h0, 1);
    do_op(1, 2'd1, 0, 32'h2002, 32'h0, 5'd3, 2, 1, 32'h0, 1);

    // Misaligned load: never accepted
    @(posedge clk); #1;
    de_lsu_flag = 1; de_alu_l_flag = 1; de_alu_ls_size = 2'd2; alu_lsu_addr = 32'h1001;
    alu_int_l_misa = 1;
    #1;
    check("misa_stall", lsu_stall, 0);
    check("misa_req", lsu_bus_req, 0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("misa_req_next", lsu_bus_req, 0);
    check("misa_stall_next", lsu_stall, 0);

    // gnt withheld: fault on the 64th REQ cycle, then a stray rvalid must be ignored
    drive_op(1, 2'd2, 0, 32'h3000, 32'h0, 5'd4);
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (c == 1) idle_inputs();
      #1;
      if (c == 63) check("to_early", lsu_int_fault, 0);
      if (c == 64) begin
        check("to_fault", lsu_int_fault, 1);
        check("to_is_store", lsu_int_is_store, 0);
        check("to_stall", lsu_stall, 0);
        check("to_wb", lsu_wb_valid, 0);
      end
    end
    @(posedge clk); #1;
    bus_rvalid = 1; bus_rdata = 32'h5555_AAAA;
    #1;
    check("stray_req", lsu_bus_req, 0);
    check("stray_wb", lsu_wb_valid, 0);
    check("stray_fault", lsu_int_fault, 0);
    check("stray_stall", lsu_stall, 0);
    @(posedge clk); #1;
    bus_rvalid = 0;

    // Asynchronous reset while in WAIT
    drive_op(0, 2'd2, 0, 32'h4000, 32'hA5A5_A5A5, 5'd0);
    @(posedge clk); #1;
    idle_inputs();
    bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    #1;
    rst_n = 0; bus_rvalid = 1;
    #1;
    check("arst_req", lsu_bus_req, 0);
    check("arst_addr", lsu_bus_addr, 0);
    check("arst_be", lsu_bus_be, 0);
    check("arst_stall", lsu_stall, 0);
    check("arst_wb", lsu_wb_valid, 0);
    check("arst_fault", lsu_int_fault, 0);
    #1;
    rst_n = 1; bus_rvalid = 0;
    do_op(1, 2'd1, 1, 32'h4006, 32'h0, 5'd12, 0, 1, 32'hF00D_0BAD, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
